// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states and address constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSREQ = 2'd1,
    RESP   = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC          = 32'hbfc0_0000;
  localparam logic [31:0] ADDR_MASK_DEFAULT = 32'h1fff_ffff;

endpackage

// File: rtl/fetch_hit_buffer.sv
// One-entry instruction buffer: word tag, data and valid, with lookup, fill and invalidate.
module fetch_hit_buffer (
  input  logic        clk,
  input  logic        resetn,
  input  logic [29:0] lookup_tag,
  output logic        hit,
  output logic [31:0] hit_data,
  input  logic        fill,
  input  logic [29:0] fill_tag,
  input  logic [31:0] fill_data,
  input  logic        inv
);

  logic        valid;
  logic [29:0] tag;
  logic [31:0] data;

  // Invalidate takes priority over a same-cycle fill; the filled data is still delivered upstream.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else begin
      if (inv) begin
        valid <= 1'b0;
      end else if (fill) begin
        valid <= 1'b1;
      end
      if (fill) begin
        tag  <= fill_tag;
        data <= fill_data;
      end
    end
  end

  assign hit      = valid && (tag == lookup_tag);
  assign hit_data = data;

endmodule

// File: rtl/inst_fetch_responder.sv
// Instruction fetch responder: one-entry hit buffer in front of a req/ack bus with timeout.
module inst_fetch_responder
  import cpu_pkg::*;
#(
  parameter logic [31:0] ADDR_MASK = ADDR_MASK_DEFAULT,
  parameter int          TIMEOUT   = 255,
  parameter int          TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  input  logic        inv,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_valid,
  output logic        inst_adel,
  output logic        inst_buserr,
  output logic        fetch_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  fetch_state_t         state, state_next;
  logic [TIMEOUT_W-1:0] cnt, cnt_next;

  logic [29:0] req_tag;
  logic        misaligned;
  logic        hit;
  logic [31:0] hit_data;
  logic        fill;
  logic        load_addr;
  logic        load_resp;
  logic [31:0] resp_rdata;
  logic        resp_adel;
  logic        resp_buserr;

  assign req_tag    = inst_sram_addr[31:2] & ADDR_MASK[31:2];
  assign misaligned = |inst_sram_addr[1:0];

  fetch_hit_buffer u_hit_buffer (
    .clk        (clk),
    .resetn     (resetn),
    .lookup_tag (req_tag),
    .hit        (hit),
    .hit_data   (hit_data),
    .fill       (fill),
    .fill_tag   (mem_addr[31:2]),
    .fill_data  (mem_rdata),
    .inv        (inv)
  );

  always_comb begin
    state_next  = state;
    cnt_next    = '0;
    fill        = 1'b0;
    load_addr   = 1'b0;
    load_resp   = 1'b0;
    resp_rdata  = '0;
    resp_adel   = 1'b0;
    resp_buserr = 1'b0;
    fetch_stall = 1'b0;
    unique case (state)
      IDLE, RESP: begin
        if (inst_sram_en) begin
          if (misaligned) begin
            state_next = RESP;
            load_resp  = 1'b1;
            resp_adel  = 1'b1;
          end else if (hit) begin
            state_next = RESP;
            load_resp  = 1'b1;
            resp_rdata = hit_data;
          end else begin
            state_next  = BUSREQ;
            load_addr   = 1'b1;
            fetch_stall = 1'b1;
          end
        end else begin
          state_next = IDLE;
        end
      end
      BUSREQ: begin
        fetch_stall = 1'b1;
        // An ack on the final allowed cycle still wins over the timeout.
        if (mem_ack) begin
          state_next = RESP;
          fill       = 1'b1;
          load_resp  = 1'b1;
          resp_rdata = mem_rdata;
        end else if (cnt == TIMEOUT_W'(TIMEOUT - 1)) begin
          state_next  = RESP;
          load_resp   = 1'b1;
          resp_buserr = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      cnt             <= '0;
      mem_addr        <= '0;
      inst_sram_rdata <= '0;
      inst_adel       <= 1'b0;
      inst_buserr     <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (load_addr) begin
        mem_addr <= {req_tag, 2'b00};
      end
      if (load_resp) begin
        inst_sram_rdata <= resp_rdata;
        inst_adel       <= resp_adel;
        inst_buserr     <= resp_buserr;
      end
    end
  end

  assign inst_valid = (state == RESP);
  assign mem_req    = (state == BUSREQ);

endmodule
